// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issue sequencer: operation codes, default
//   per-operation ENABLE latencies, the command record carried through the
//   command FIFO, and the sequencer state encoding.
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MULT = 2'b10,
        OP_DIV  = 2'b11
    } alu_op_t;

    localparam int DEF_ADD_LAT = 1;
    localparam int DEF_SUB_LAT = 1;
    localparam int DEF_MUL_LAT = 8;
    localparam int DEF_DIV_LAT = 8;

    // {op, a, b}
    localparam int CMD_W = 18;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EXEC    = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
//   Synchronous command FIFO for the ALU sequencer. Head entry is presented
//   combinationally on rd_data; pop advances it on the clock edge.
//
//   CLK      in   clock, rising edge
//   RESET    in   synchronous, active-low reset
//   push     in   write wr_data (ignored when full)
//   pop      in   drop head entry (ignored when empty)
//   wr_data  in   entry to write
//   rd_data  out  current head entry
//   full     out  no free entries
//   empty    out  no valid entries
//   count    out  number of valid entries
// ---------------------------------------------------------------------------
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Issue stage for the 8-bit signed ALU. Buffers commands, holds ENABLE
//   for a fixed per-operation latency, captures the ALU outputs and offers
//   them on a valid/ready response port. DIV by zero is answered with
//   rsp_err without invoking the ALU.
//
//   CLK, RESET                  clock / synchronous active-low reset
//   cmd_valid/ready/op/a/b      command port (valid/ready)
//   operand_a/b, alu_operation  operands and op to the ALU (held outside EXEC)
//   ENABLE                      ALU enable, high for LAT(op) cycles
//   alu_result/result2/carry_out/flags   ALU outputs
//   rsp_valid/ready/op/result/result2/carry/flags/err   response port
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | nothing in flight; pops the FIFO head when one is present
//   EXEC     | ENABLE high, down-counter runs to zero
//   CAPTURE  | ENABLE low for one cycle; ALU outputs registered at its end
//   RESP     | response offered; on handshake pop next command or go IDLE
// ---------------------------------------------------------------------------
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADD_LAT    = DEF_ADD_LAT,
    parameter int SUB_LAT    = DEF_SUB_LAT,
    parameter int MUL_LAT    = DEF_MUL_LAT,
    parameter int DIV_LAT    = DEF_DIV_LAT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [7:0] operand_a,
    output logic [7:0] operand_b,
    output logic [1:0] alu_operation,
    output logic       ENABLE,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_result2,
    input  logic       alu_carry_out,
    input  logic [3:0] alu_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_op,
    output logic [7:0] rsp_result,
    output logic [7:0] rsp_result2,
    output logic       rsp_carry,
    output logic [3:0] rsp_flags,
    output logic       rsp_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

    cmd_t        fifo_wr;
    cmd_t        fifo_head;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;

    seq_state_t  state;
    seq_state_t  state_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [7:0]  head_lat_m1;
    logic        head_is_div0;
    logic        issue_div0;
    logic        do_capture;

    assign fifo_wr   = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign cmd_ready = (fifo_count < DEPTH_CNT);
    assign fifo_push = cmd_valid && !fifo_full;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (fifo_wr),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        head_lat_m1 = 8'(DIV_LAT - 1);
        case (fifo_head.op)
            OP_ADD:  head_lat_m1 = 8'(ADD_LAT - 1);
            OP_SUB:  head_lat_m1 = 8'(SUB_LAT - 1);
            OP_MULT: head_lat_m1 = 8'(MUL_LAT - 1);
            default: head_lat_m1 = 8'(DIV_LAT - 1);
        endcase
    end

    assign head_is_div0 = (fifo_head.op == OP_DIV) && (fifo_head.b == 8'd0);
    assign issue_div0   = fifo_pop && head_is_div0;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        fifo_pop   = 1'b0;
        do_capture = 1'b0;
        case (state)
            ST_IDLE: begin
                fifo_pop = !fifo_empty;
            end
            ST_EXEC: begin
                if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
                else             state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                do_capture = 1'b1;
                state_nxt  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    fifo_pop  = !fifo_empty;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A pop from IDLE or RESP issues the head directly; DIV by zero
        // bypasses the ALU and is answered on the very next cycle.
        if (fifo_pop) begin
            if (head_is_div0) begin
                state_nxt = ST_RESP;
            end else begin
                state_nxt = ST_EXEC;
                cnt_nxt   = head_lat_m1;
            end
        end
    end

    assign ENABLE    = (state == ST_EXEC);
    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state         <= ST_IDLE;
            cnt           <= 8'd0;
            operand_a     <= 8'd0;
            operand_b     <= 8'd0;
            alu_operation <= 2'd0;
            rsp_op        <= 2'd0;
            rsp_result    <= 8'd0;
            rsp_result2   <= 8'd0;
            rsp_carry     <= 1'b0;
            rsp_flags     <= 4'd0;
            rsp_err       <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (fifo_pop) begin
                operand_a     <= fifo_head.a;
                operand_b     <= fifo_head.b;
                alu_operation <= fifo_head.op;
            end
            if (issue_div0) begin
                rsp_op      <= fifo_head.op;
                rsp_result  <= 8'd0;
                rsp_result2 <= 8'd0;
                rsp_carry   <= 1'b0;
                rsp_flags   <= 4'd0;
                rsp_err     <= 1'b1;
            end else if (do_capture) begin
                rsp_op      <= alu_operation;
                rsp_result  <= alu_result;
                rsp_result2 <= alu_result2;
                rsp_carry   <= alu_carry_out;
                rsp_flags   <= alu_flags;
                rsp_err     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//   Self-checking bench for alu_sequencer. A behavioural ALU drives valid
//   outputs only after an ENABLE run of the expected length (junk otherwise);
//   expected responses come from a queue filled from each accepted command.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;
    import alu_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [1:0] alu_operation;
    logic       ENABLE;
    logic [7:0] alu_result = 8'h00;
    logic [7:0] alu_result2 = 8'h00;
    logic       alu_carry_out = 1'b0;
    logic [3:0] alu_flags = 4'h0;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_op;
    logic [7:0] rsp_result;
    logic [7:0] rsp_result2;
    logic       rsp_carry;
    logic [3:0] rsp_flags;
    logic       rsp_err;

    alu_sequencer dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .alu_operation (alu_operation),
        .ENABLE        (ENABLE),
        .alu_result    (alu_result),
        .alu_result2   (alu_result2),
        .alu_carry_out (alu_carry_out),
        .alu_flags     (alu_flags),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_op        (rsp_op),
        .rsp_result    (rsp_result),
        .rsp_result2   (rsp_result2),
        .rsp_carry     (rsp_carry),
        .rsp_flags     (rsp_flags),
        .rsp_err       (rsp_err)
    );

    initial forever #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] r2;
        logic       c;
        logic [3:0] f;
    } alu_out_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] r;
        logic [7:0] r2;
        logic       c;
        logic [3:0] f;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b00:   return 1;
            2'b01:   return 1;
            2'b10:   return 8;
            default: return 8;
        endcase
    endfunction

    function automatic alu_out_t alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        alu_out_t   o;
        int         ia;
        int         ib;
        int         q;
        logic [8:0] s;
        logic       v;
        o  = '0;
        v  = 1'b0;
        ia = int'($signed(a));
        ib = int'($signed(b));
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                o.r = s[7:0]; o.c = s[8];
                v = (ia + ib > 127) || (ia + ib < -128);
            end
            2'b01: begin
                s = {1'b0, a} - {1'b0, b};
                o.r = s[7:0]; o.c = s[8];
                v = (ia - ib > 127) || (ia - ib < -128);
            end
            2'b10: begin
                q = ia * ib;
                o.r = q[7:0]; o.r2 = q[15:8];
                v = (q > 127) || (q < -128);
            end
            default: begin
                if (ib != 0) begin
                    q = ia / ib;
                    o.r = q[7:0]; o.r2 = 8'(ia % ib);
                    v = (q > 127);
                end
            end
        endcase
        o.f = {o.r[7], (o.r == 8'd0), o.c, v};
        return o;
    endfunction

    // Behavioural ALU plus ENABLE / operand-stability observers.
    int         en_run   = 0;
    int         last_run = 0;
    int         en_total = 0;
    int         stab_bad = 0;
    logic       prev_en  = 1'b0;
    logic [17:0] prev_ops = '0;

    always @(negedge CLK) begin
        alu_out_t o;
        if (ENABLE) begin
            if (prev_en && ({alu_operation, operand_a, operand_b} != prev_ops)) stab_bad++;
            en_run++;
            en_total++;
            alu_result = 8'hA5; alu_result2 = 8'h5A; alu_carry_out = 1'b1; alu_flags = 4'hF;
        end else if (en_run != 0) begin
            last_run = en_run;
            if (en_run == lat_of(alu_operation)) begin
                o = alu_ref(alu_operation, operand_a, operand_b);
                alu_result = o.r; alu_result2 = o.r2; alu_carry_out = o.c; alu_flags = o.f;
            end else begin
                alu_result = 8'hEE; alu_result2 = 8'hEE; alu_carry_out = 1'b1; alu_flags = 4'hE;
            end
            en_run = 0;
        end
        prev_en  = ENABLE;
        prev_ops = {alu_operation, operand_a, operand_b};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        rsp_t     e;
        alu_out_t o;
        if (op == 2'b11 && b == 8'd0) begin
            e = {op, 8'd0, 8'd0, 1'b0, 4'd0, 1'b1};
        end else begin
            o = alu_ref(op, a, b);
            e = {op, o.r, o.r2, o.c, o.f, 1'b0};
        end
        exp_q.push_back(e);
    endtask

    task automatic check_rsp(input string tag);
        rsp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_rsp"}, 32'(rsp_valid), 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rsp"}, 32'({rsp_op, rsp_result, rsp_result2, rsp_carry, rsp_flags, rsp_err}), 32'(e));
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic drive_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, output int hs);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        hs = -1;
        for (int i = 0; i < 50 && hs < 0; i++) begin
            if (cmd_ready) begin
                hs = cyc;
                push_exp(op, a, b);
            end
            @(negedge CLK);
        end
        cmd_valid = 1'b0;
        if (hs < 0) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic wait_rsp(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            if (rsp_valid) at = cyc;
            else @(negedge CLK);
        end
        if (at < 0) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    // Leaves the bench at the negedge of the response cycle.
    task automatic single(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input int exp_en, input string tag);
        int hs;
        int at;
        int e0;
        int s0;
        e0 = en_total;
        s0 = stab_bad;
        drive_cmd(op, a, b, hs);
        wait_rsp(40, at);
        chk({tag, "_latency"}, 32'(at - hs), 32'(exp_lat));
        chk({tag, "_enable_cycles"}, 32'(en_total - e0), 32'(exp_en));
        if (exp_en > 0) chk({tag, "_enable_run"}, 32'(last_run), 32'(exp_en));
        chk({tag, "_operand_stable"}, 32'(stab_bad - s0), 32'd0);
        check_rsp(tag);
    endtask

    initial begin
        int   hs;
        int   n;
        int   last;
        logic sent6;
        logic took;

        RESET = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 8'd0; cmd_b = 8'd0; rsp_ready = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_enable", 32'(ENABLE), 32'd0);
        chk("rst_operands", 32'({alu_operation, operand_a, operand_b}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_op, rsp_result, rsp_result2, rsp_carry, rsp_flags, rsp_err}), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        RESET = 1'b1;
        @(negedge CLK);

        // ADD -5 + -2
        single(2'b00, 8'hFB, 8'hFE, 4, 1, "add");
        chk("add_result", 32'({rsp_op, rsp_err, rsp_result}), 32'({2'b00, 1'b0, 8'hF9}));
        @(negedge CLK);

        // MULT 10 * 4
        single(2'b10, 8'd10, 8'd4, 11, 8, "mult");
        chk("mult_product", 32'({rsp_result2, rsp_result}), 32'd40);
        @(negedge CLK);

        // DIV 21 / 0: no ALU activity, error response
        single(2'b11, 8'd21, 8'd0, 2, 0, "div0");
        chk("div0_data", 32'({rsp_err, rsp_result, rsp_result2, rsp_carry, rsp_flags}), 32'({1'b1, 21'd0}));
        @(negedge CLK);

        // Back-pressure: six ADDs with the response port stalled
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'(i * 10); cmd_b = 8'(i + 1);
            chk("fill_ready", 32'(cmd_ready), 32'd1);
            push_exp(2'b00, cmd_a, cmd_b);
            @(negedge CLK);
        end
        cmd_a = 8'd50; cmd_b = 8'd6;
        chk("fifo_full_ready", 32'(cmd_ready), 32'd0);
        repeat (3) @(negedge CLK);
        chk("stall_ready", 32'(cmd_ready), 32'd0);
        chk("stall_rsp", 32'({rsp_valid, rsp_result}), 32'({1'b1, 8'd1}));
        rsp_ready = 1'b1;
        sent6 = 1'b0; n = 0; last = -1;
        for (int i = 0; i < 80 && n < 6; i++) begin
            if (sent6) begin
                cmd_valid = 1'b0;
            end else if (cmd_ready) begin
                push_exp(2'b00, 8'd50, 8'd6);
                sent6 = 1'b1;
            end
            if (rsp_valid) begin
                check_rsp("drain");
                if (n > 0) chk("drain_gap", 32'(cyc - last), 32'd3);
                last = cyc;
                n++;
            end
            @(negedge CLK);
        end
        cmd_valid = 1'b0;
        chk("drain_count", 32'(n), 32'd6);
        @(negedge CLK);

        // Reset in the middle of a MULT
        drive_cmd(2'b10, 8'd7, 8'd9, hs);
        repeat (4) @(negedge CLK);
        chk("pre_reset_enable", 32'(ENABLE), 32'd1);
        RESET = 1'b0;
        @(negedge CLK);
        chk("mid_reset_outputs", 32'({ENABLE, rsp_valid, cmd_ready}), 32'(3'b001));
        RESET = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        single(2'b01, 8'hFD, 8'hFC, 4, 1, "sub");
        chk("sub_result", 32'({rsp_op, rsp_result}), 32'({2'b01, 8'h01}));
        @(negedge CLK);

        // Randomized traffic with random back-pressure
        took = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!cmd_valid || took) begin
                cmd_valid = ($urandom_range(0, 2) != 0);
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_a     = 8'($urandom);
                cmd_b     = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                took      = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                push_exp(cmd_op, cmd_a, cmd_b);
                took = 1'b1;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (rsp_valid && rsp_ready) check_rsp("rand");
            @(negedge CLK);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
            if (rsp_valid) check_rsp("rand_drain");
            @(negedge CLK);
        end
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
